// File: rtl/mux32_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 result-path arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Pointer names the last winner, so requester 0 is first in line out of reset.
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

endpackage

// File: rtl/mux32_rr_arbiter_if.sv
// Requester and consumer bundle of the arbiter; slave is the arbiter's view.
interface mux32_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] REQ_VALID;
  logic [31:0]        REQ_DATA0;
  logic [31:0]        REQ_DATA1;
  logic [31:0]        REQ_DATA2;
  logic [31:0]        REQ_DATA3;
  logic [NUM_REQ-1:0] REQ_READY;
  logic               OUT_VALID;
  logic [31:0]        OUT_DATA;
  logic [SEL_W-1:0]   OUT_SRC;
  logic               OUT_READY;
  logic               BUSY;

  modport slave (
    input  REQ_VALID, REQ_DATA0, REQ_DATA1, REQ_DATA2, REQ_DATA3, OUT_READY,
    output REQ_READY, OUT_VALID, OUT_DATA, OUT_SRC, BUSY
  );

  modport master (
    output REQ_VALID, REQ_DATA0, REQ_DATA1, REQ_DATA2, REQ_DATA3, OUT_READY,
    input  REQ_READY, OUT_VALID, OUT_DATA, OUT_SRC, BUSY
  );

endinterface

// File: rtl/mux32_4x1.sv
// Existing 32-bit 4:1 data mux shared by all requesters.
module MUX32_4x1 (
  input  logic [31:0] I0,
  input  logic [31:0] I1,
  input  logic [31:0] I2,
  input  logic [31:0] I3,
  input  logic [1:0]  S,
  output logic [31:0] Y
);

  always_comb begin
    case (S)
      2'd0:    Y = I0;
      2'd1:    Y = I1;
      2'd2:    Y = I2;
      default: Y = I3;
    endcase
  end

endmodule

// File: rtl/mux32_rr_arbiter_rr_pick4.sv
// Rotating-priority picker: first valid requester after the pointer wins.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_winner,
  output logic               o_any_valid
);

  logic [SEL_W-1:0] w_idx;

  // Scan from lowest to highest priority so the closest candidate overwrites last.
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = i_ptr + SEL_W'(k);
      if (i_valid[w_idx]) o_winner = w_idx;
    end
  end

  assign o_any_valid = |i_valid;

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter with bounded bursts feeding a registered 32-bit output.
module mux32_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 4
) (
  input  logic CLK,
  input  logic RST,
  mux32_rr_arbiter_if.slave bus
);

  arb_state_t         r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
  logic [SEL_W-1:0]   r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [SEL_W-1:0]   w_winner, w_sel;
  logic               w_any, w_accept, w_xfer;
  logic [NUM_REQ-1:0] w_ready;
  logic               r_out_valid;
  logic [31:0]        r_out_data, w_mux_y;
  logic [SEL_W-1:0]   r_out_src;

  rr_pick4 u_pick (
    .i_valid     (bus.REQ_VALID),
    .i_ptr       (r_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any)
  );

  MUX32_4x1 u_mux (
    .I0 (bus.REQ_DATA0),
    .I1 (bus.REQ_DATA1),
    .I2 (bus.REQ_DATA2),
    .I3 (bus.REQ_DATA3),
    .S  (w_sel),
    .Y  (w_mux_y)
  );

  assign w_accept  = !r_out_valid || bus.OUT_READY;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_xfer    = |w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_ready     = '0;
    w_sel       = r_owner;
    case (r_state)
      ARB_IDLE: begin
        w_sel = w_winner;
        if (w_accept && w_any) begin
          w_ready[w_winner] = 1'b1;
          w_owner_nxt       = w_winner;
          w_cnt_nxt         = CNT_W'(1);
          if (BURST_MAX == 1) w_ptr_nxt = w_winner;
          else                w_state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // A vanished owner releases the burst at the cost of one bubble cycle.
        if (!bus.REQ_VALID[r_owner]) begin
          w_ptr_nxt   = r_owner;
          w_state_nxt = ARB_IDLE;
        end else if (w_accept) begin
          w_ready[r_owner] = 1'b1;
          w_cnt_nxt        = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(BURST_MAX)) begin
            w_ptr_nxt   = r_owner;
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= PTR_RST;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_y;
        r_out_src   <= w_sel;
      end else if (bus.OUT_READY) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.REQ_READY = RST ? w_ready : '0;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.OUT_DATA  = r_out_data;
  assign bus.OUT_SRC   = r_out_src;
  assign bus.BUSY      = (r_state == ARB_GRANT);

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Drives a BURST_MAX=1 and a BURST_MAX=4 arbiter with identical stimulus against a reference model.
module tb_mux32_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  tb_valid = '0;
  logic [31:0] tb_data [4];
  logic        tb_ordy = 1'b1;

  always #5 CLK = ~CLK;

  mux32_rr_arbiter_if bus1();
  mux32_rr_arbiter_if bus4();

  assign bus1.REQ_VALID = tb_valid;
  assign bus1.REQ_DATA0 = tb_data[0];
  assign bus1.REQ_DATA1 = tb_data[1];
  assign bus1.REQ_DATA2 = tb_data[2];
  assign bus1.REQ_DATA3 = tb_data[3];
  assign bus1.OUT_READY = tb_ordy;
  assign bus4.REQ_VALID = tb_valid;
  assign bus4.REQ_DATA0 = tb_data[0];
  assign bus4.REQ_DATA1 = tb_data[1];
  assign bus4.REQ_DATA2 = tb_data[2];
  assign bus4.REQ_DATA3 = tb_data[3];
  assign bus4.OUT_READY = tb_ordy;

  mux32_rr_arbiter #(.BURST_MAX(1), .CNT_W(4)) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1.slave));
  mux32_rr_arbiter #(.BURST_MAX(4), .CNT_W(4)) u_dut4 (.CLK(CLK), .RST(RST), .bus(bus4.slave));

  logic [3:0]  a_rdy [2];
  logic        a_ov  [2];
  logic [31:0] a_od  [2];
  logic [1:0]  a_os  [2];
  logic        a_bsy [2];
  assign a_rdy[0] = bus1.REQ_READY;  assign a_rdy[1] = bus4.REQ_READY;
  assign a_ov[0]  = bus1.OUT_VALID;  assign a_ov[1]  = bus4.OUT_VALID;
  assign a_od[0]  = bus1.OUT_DATA;   assign a_od[1]  = bus4.OUT_DATA;
  assign a_os[0]  = bus1.OUT_SRC;    assign a_os[1]  = bus4.OUT_SRC;
  assign a_bsy[0] = bus1.BUSY;       assign a_bsy[1] = bus4.BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner < 0 means no burst is locked; last names the most recent owner.
  int          m_last [2];
  int          m_own  [2];
  int          m_used [2];
  logic        m_ov   [2];
  logic [31:0] m_od   [2];
  int          m_os   [2];
  logic [3:0]  m_rdy  [2];

  typedef struct {
    logic [3:0]  valid;
    logic        ordy;
    logic [31:0] d2;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  src;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [10];

  int bseq [9]   = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  int bbusy [9]  = '{1, 1, 1, 0, 1, 1, 1, 0, 1};
  int pbusy [6]  = '{1, 1, 0, 1, 1, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 3; m_own[d] = -1; m_used[d] = 0;
      m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = 0; m_rdy[d] = '0;
    end
  endtask

  task automatic model_step(input int d);
    int   budget, w, src, cand;
    logic acc;
    budget = (d == 0) ? 1 : 4;
    acc    = !m_ov[d] || tb_ordy;
    src    = -1;
    if (m_own[d] < 0) begin
      w = -1;
      for (int off = 1; off <= 4; off++) begin
        cand = (m_last[d] + off) % 4;
        if (w < 0 && tb_valid[cand]) w = cand;
      end
      if (acc && w >= 0) begin
        src = w;
        if (budget == 1) m_last[d] = w;
        else begin m_own[d] = w; m_used[d] = 1; end
      end
    end else if (!tb_valid[m_own[d]]) begin
      m_last[d] = m_own[d];
      m_own[d]  = -1;
    end else if (acc) begin
      src = m_own[d];
      m_used[d]++;
      if (m_used[d] == budget) begin m_last[d] = m_own[d]; m_own[d] = -1; end
    end
    m_rdy[d] = '0;
    if (src >= 0) begin
      m_rdy[d][src] = 1'b1;
      m_ov[d] = 1'b1; m_od[d] = tb_data[src]; m_os[d] = src;
    end else if (tb_ordy) begin
      m_ov[d] = 1'b0;
    end
  endtask

  task automatic step_pre();
    #1;
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      chk($sformatf("d%0d ready", d), {28'b0, a_rdy[d]}, {28'b0, m_rdy[d]});
    end
  endtask

  task automatic step_post();
    @(posedge CLK); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d out_valid", d), {31'b0, a_ov[d]}, {31'b0, m_ov[d]});
      chk($sformatf("d%0d out_data", d), a_od[d], m_od[d]);
      chk($sformatf("d%0d out_src", d), {30'b0, a_os[d]}, 32'(m_os[d]));
      chk($sformatf("d%0d busy", d), {31'b0, a_bsy[d]}, {31'b0, (m_own[d] >= 0)});
    end
  endtask

  task automatic step();
    step_pre();
    step_post();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    tb_valid = 4'b1111;
    tb_ordy = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst ready", d), {28'b0, a_rdy[d]}, 32'h0);
      chk($sformatf("d%0d rst out_valid", d), {31'b0, a_ov[d]}, 32'h0);
      chk($sformatf("d%0d rst out_data", d), a_od[d], 32'h0);
      chk($sformatf("d%0d rst out_src", d), {30'b0, a_os[d]}, 32'h0);
      chk($sformatf("d%0d rst busy", d), {31'b0, a_bsy[d]}, 32'h0);
    end
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    tb_valid = '0;
  endtask

  task automatic set_data_10();
    for (int i = 0; i < 4; i++) tb_data[i] = 32'h10 + 32'(i);
  endtask

  initial begin
    tbl[0] = '{4'b0100, 1'b1, 32'hA5A5_0002, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0002};
    tbl[1] = '{4'b1000, 1'b1, 32'h12,        4'b1000, 1'b1, 2'd3, 32'h13};
    tbl[2] = '{4'b1111, 1'b1, 32'h12,        4'b0001, 1'b1, 2'd0, 32'h10};
    tbl[3] = '{4'b1111, 1'b1, 32'h12,        4'b0010, 1'b1, 2'd1, 32'h11};
    tbl[4] = '{4'b1111, 1'b1, 32'h12,        4'b0100, 1'b1, 2'd2, 32'h12};
    tbl[5] = '{4'b1111, 1'b1, 32'h12,        4'b1000, 1'b1, 2'd3, 32'h13};
    tbl[6] = '{4'b1111, 1'b1, 32'h12,        4'b0001, 1'b1, 2'd0, 32'h10};
    tbl[7] = '{4'b1111, 1'b0, 32'h12,        4'b0000, 1'b1, 2'd0, 32'h10};
    tbl[8] = '{4'b1111, 1'b0, 32'h12,        4'b0000, 1'b1, 2'd0, 32'h10};
    tbl[9] = '{4'b0000, 1'b1, 32'h12,        4'b0000, 1'b0, 2'd0, 32'h10};

    set_data_10();
    model_reset();

    // Single requester, then rotation and a short stall on the BURST_MAX=1 instance.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      tb_valid = tbl[r].valid;
      tb_ordy  = tbl[r].ordy;
      tb_data[2] = tbl[r].d2;
      step_pre();
      chk($sformatf("vec%0d ready", r), {28'b0, a_rdy[0]}, {28'b0, tbl[r].rdy});
      step_post();
      chk($sformatf("vec%0d out_valid", r), {31'b0, a_ov[0]}, {31'b0, tbl[r].ov});
      chk($sformatf("vec%0d out_src", r), {30'b0, a_os[0]}, {30'b0, tbl[r].src});
      chk($sformatf("vec%0d out_data", r), a_od[0], tbl[r].data);
      @(negedge CLK);
    end

    // Burst limit with two competing requesters.
    do_reset();
    set_data_10();
    tb_valid = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      step_pre();
      step_post();
      chk($sformatf("burst%0d src", k), {30'b0, a_os[1]}, 32'(bseq[k]));
      chk($sformatf("burst%0d busy", k), {31'b0, a_bsy[1]}, 32'(bbusy[k]));
      @(negedge CLK);
    end

    // Backpressure mid-burst: stalls must not consume budget or lose beats.
    do_reset();
    tb_valid = 4'b0001;
    tb_data[0] = 32'hB000_0000;
    step();
    tb_data[0] = 32'hB000_0001;
    tb_ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_pre();
      chk($sformatf("stall%0d ready", k), {28'b0, a_rdy[1]}, 32'h0);
      step_post();
      chk($sformatf("stall%0d data", k), a_od[1], 32'hB000_0000);
      chk($sformatf("stall%0d src", k), {30'b0, a_os[1]}, 32'h0);
      @(negedge CLK);
    end
    tb_ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step_pre();
      step_post();
      chk($sformatf("resume%0d data", k), a_od[1], 32'hB000_0001 + 32'(k));
      chk($sformatf("resume%0d busy", k), {31'b0, a_bsy[1]}, 32'(pbusy[k]));
      @(negedge CLK);
      if (m_rdy[1][0]) tb_data[0] = tb_data[0] + 32'h1;
    end

    // Owner 3 drops after two beats while requester 0 waits.
    do_reset();
    set_data_10();
    tb_valid = 4'b1000;
    step();
    tb_valid = 4'b1001;
    step_pre();
    step_post();
    chk("drop beat2 src", {30'b0, a_os[1]}, 32'h3);
    @(negedge CLK);
    tb_valid = 4'b0001;
    step_pre();
    chk("drop bubble ready", {28'b0, a_rdy[1]}, 32'h0);
    step_post();
    chk("drop bubble busy", {31'b0, a_bsy[1]}, 32'h0);
    chk("drop bubble valid", {31'b0, a_ov[1]}, 32'h0);
    @(negedge CLK);
    step_pre();
    chk("drop regrant ready", {28'b0, a_rdy[1]}, 32'h1);
    step_post();
    chk("drop regrant src", {30'b0, a_os[1]}, 32'h0);
    chk("drop regrant busy", {31'b0, a_bsy[1]}, 32'h1);
    chk("drop regrant data", a_od[1], 32'h10);
    @(negedge CLK);

    // Asynchronous reset between edges while the BURST_MAX=4 instance is locked.
    chk("pre-reset busy", {31'b0, a_bsy[1]}, 32'h1);
    #3;
    RST = 1'b0;
    #1;
    chk("async out_valid", {31'b0, a_ov[1]}, 32'h0);
    chk("async out_data", a_od[1], 32'h0);
    chk("async busy", {31'b0, a_bsy[1]}, 32'h0);
    chk("async ready", {28'b0, a_rdy[1]}, 32'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    tb_valid = 4'b0110;
    step_pre();
    step_post();
    chk("post-reset src d4", {30'b0, a_os[1]}, 32'h1);
    chk("post-reset src d1", {30'b0, a_os[0]}, 32'h1);
    @(negedge CLK);

    // Randomized traffic; data only changes while a requester is idle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!tb_valid[i]) begin
          tb_data[i]  = $urandom;
          tb_valid[i] = ($urandom_range(0, 1) == 1);
        end else if ($urandom_range(0, 7) == 0) begin
          tb_valid[i] = 1'b0;
        end
      end
      tb_ordy = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux32_rr_arbiter.md
Name: mux32_rr_arbiter

Overview:
- Shares one 32-bit result path between four requesters using round-robin arbitration with bounded burst ownership.
- The winning requester index drives the select of the existing 32-bit 4:1 mux (MUX32_4x1).
- The mux output is captured into a single-entry output register with a valid/ready handshake.
- Sits in front of any consumer that would otherwise need its own 4:1 operand/result mux.

Parameters:
- BURST_MAX, 4: max consecutive beats one owner may transfer before rotation. Legal range 1..15.
- CNT_W, 4: width of the beat counter. Must hold BURST_MAX.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- REQ_VALID  input  4  per-requester data valid.
- REQ_DATA0..REQ_DATA3  input  32 each  requester payloads.
- REQ_READY  output  4  one-hot (or zero) accept strobe to requesters.
- OUT_VALID  output  1  output register holds a beat.
- OUT_DATA  output  32  captured payload.
- OUT_SRC  output  2  index of the requester that supplied OUT_DATA.
- OUT_READY  input  1  consumer accepts the beat.
- BUSY  output  1  high while in GRANT (burst locked).

Behaviour:
- Reset (RST low, async):
  - OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, BUSY=0, state=IDLE, beat_cnt=0.
  - Priority pointer PTR=3, so requester 0 wins first.
  - REQ_READY forced to 0 while RST is low.
- accept = !OUT_VALID | OUT_READY (combinational). REQ_READY is all-zero whenever accept=0.
- A transfer occurs on a clock edge where REQ_VALID[i] & REQ_READY[i]:
  - OUT_DATA <= mux output with S=i; OUT_SRC <= i; OUT_VALID <= 1.
  - Latency from transfer edge to OUT_VALID: 1 cycle.
- If no transfer occurs and OUT_READY=1, then OUT_VALID <= 0.
- While OUT_VALID & !OUT_READY: OUT_DATA and OUT_SRC are held stable.
- Requesters must hold REQ_DATAi stable while REQ_VALID[i] & !REQ_READY[i].
- IDLE state:
  - winner = first set REQ_VALID bit scanning PTR+1, PTR+2, PTR+3, PTR (mod 4).
  - If accept and any valid: REQ_READY[winner]=1, owner<=winner, beat_cnt<=1.
  - If BURST_MAX==1: stay in IDLE, PTR<=winner.
  - Else: go to GRANT.
  - If no valid requester: stay in IDLE. No outputs change except the OUT_VALID drain.
- GRANT state: only the owner is eligible.
  - If REQ_VALID[owner]=0 at the start of the cycle: no transfer, PTR<=owner, go to IDLE. This costs one bubble cycle.
  - Else if accept: REQ_READY[owner]=1, beat_cnt++. If beat_cnt+1==BURST_MAX: PTR<=owner, go to IDLE.
  - Else (accept=0): hold state and beat_cnt. Stalls do not consume burst budget.
- BUSY = (state==GRANT).
- Simultaneous events:
  - OUT_READY and a new transfer on the same edge: OUT_VALID stays 1 and the new data replaces the old. Full throughput: one beat per cycle.
  - All four requesters valid with BURST_MAX=1: grants rotate 0,1,2,3,0,...
- Starvation bound: any valid requester is granted within 3*BURST_MAX + 3 cycles, assuming OUT_READY=1.
- Reset mid-burst: everything returns to reset values immediately. An in-flight OUT beat is discarded.

Decomposition:
- Shared package mux_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_GRANT}
  - NUM_REQ=4, SEL_W=2
  - reset pointer constant PTR_RST=2'd3
- Sub-module rr_pick4 (combinational): inputs REQ_VALID[3:0] and PTR[1:0]; outputs winner[1:0] and any_valid.
- Data selection uses an instance of the existing MUX32_4x1 with S driven by the grant index (owner in GRANT, winner in IDLE).

Test Plan:
- Reset then single requester: after reset, REQ_VALID=4'b0100 with REQ_DATA2=32'hA5A5_0002 and OUT_READY=1, BURST_MAX=1. Expect REQ_READY=4'b0100 that cycle; next cycle OUT_VALID=1, OUT_DATA=32'hA5A5_0002, OUT_SRC=2.
- Rotation: all four valid with data 32'h10..32'h13, BURST_MAX=1, OUT_READY=1. Expect OUT_SRC sequence 0,1,2,3,0 on consecutive cycles and OUT_DATA 32'h10,11,12,13,10.
- Burst limit: BURST_MAX=4, requesters 0 and 1 continuously valid. Expect OUT_SRC 0,0,0,0,1,1,1,1,0 and BUSY high during each burst.
- Backpressure: OUT_READY held 0 for 3 cycles after the first beat. Expect OUT_DATA/OUT_SRC stable, REQ_READY=0, beat_cnt frozen; after OUT_READY=1 the burst resumes with no lost or duplicated beats.
- Owner drop: in GRANT, owner 3 deasserts REQ_VALID after 2 beats while requester 0 is valid. Expect one bubble, then OUT_SRC=0, BUSY re-asserts.
- Async reset mid-burst: RST low between clock edges during GRANT. Expect OUT_VALID=0, OUT_DATA=0, BUSY=0, REQ_READY=0 immediately; after release the first grant goes to the lowest valid index starting from 0.
